// File: rtl/cam_multi_pkg.sv
// Shared helpers for cam_multi: derived sizes and the registered search-result record.
package cam_multi_pkg;

    // Widest index the search-result record can carry. Instances use the low DEPTH_LOG2 bits.
    localparam int MAX_IDX_W = 16;

    function automatic int depth_of(input int depth_log2);
        return 1 << depth_log2;
    endfunction

    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] index;
        logic                 multi;
    } search_res_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with a "two or more bits set" flag.
module cam_prio_enc
    import cam_multi_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic [depth_of(DEPTH_LOG2)-1:0] vec,
    output logic                            valid,
    output logic [DEPTH_LOG2-1:0]           index,
    output logic                            multi
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);

    always_comb begin
        valid = 1'b0;
        index = '0;
        multi = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vec[i]) begin
                if (valid) begin
                    multi = 1'b1;
                end else begin
                    index = DEPTH_LOG2'(i);
                end
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_multi.sv
// Parametrised CAM with invalidate, multi-hit detect, occupancy and free-slot hint.
// Optional macro CAM_MULTI_BYPASS_EN: same-cycle reads/searches see that cycle's write/invalidate.
module cam_multi
    import cam_multi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    read_i,
    input  logic [DEPTH_LOG2-1:0]   read_index_i,
    input  logic                    write_i,
    input  logic [DEPTH_LOG2-1:0]   write_index_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    input  logic                    inval_i,
    input  logic [DEPTH_LOG2-1:0]   inval_index_i,
    input  logic                    search_i,
    input  logic [DATA_WIDTH-1:0]   search_data_i,
    output logic                    read_valid_o,
    output logic [DATA_WIDTH-1:0]   read_value_o,
    output logic                    search_valid_o,
    output logic [DEPTH_LOG2-1:0]   search_index_o,
    output logic                    search_multi_o,
    output logic [DEPTH_LOG2:0]     count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [DEPTH_LOG2-1:0]   free_index_o
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);
    localparam int CW    = count_width(DEPTH_LOG2);

    // Requests are single-cycle strobes with no backpressure: every asserted
    // request is accepted at the next rising edge; results are valid for one cycle after.

    logic [DATA_WIDTH-1:0] mem      [DEPTH];
    logic [DATA_WIDTH-1:0] nxt_data [DEPTH];
    logic [DATA_WIDTH-1:0] view_data[DEPTH];
    logic [DEPTH-1:0]      valid_q, nxt_valid, view_valid, match;
    logic [CW-1:0]         count_q;
    logic                  inc, dec;

    logic                  enc_valid, enc_multi;
    logic [DEPTH_LOG2-1:0] enc_index;
    logic                  free_any, free_multi;
    logic [DEPTH_LOG2-1:0] free_index;
    search_res_t           srch_d, srch_q;

    // Post-edge contents: invalidate first so a same-index write overrides it.
    always_comb begin
        nxt_valid = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            nxt_data[i] = mem[i];
        end
        if (inval_i) begin
            nxt_valid[inval_index_i] = 1'b0;
        end
        if (write_i) begin
            nxt_valid[write_index_i] = 1'b1;
            nxt_data[write_index_i]  = write_data_i;
        end
    end

    always_comb begin
`ifdef CAM_MULTI_BYPASS_EN
        view_valid = nxt_valid;
        for (int i = 0; i < DEPTH; i++) begin
            view_data[i] = nxt_data[i];
        end
`else
        view_valid = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            view_data[i] = mem[i];
        end
`endif
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = view_valid[i] && (view_data[i] == search_data_i);
        end
    end

    // A write that lands on the invalidated index cancels the decrement.
    always_comb begin
        inc = write_i && !valid_q[write_index_i];
        dec = inval_i && valid_q[inval_index_i]
              && !(write_i && (write_index_i == inval_index_i));
    end

    cam_prio_enc #(.DEPTH_LOG2(DEPTH_LOG2)) u_match_enc (
        .vec   (match),
        .valid (enc_valid),
        .index (enc_index),
        .multi (enc_multi)
    );

    cam_prio_enc #(.DEPTH_LOG2(DEPTH_LOG2)) u_free_enc (
        .vec   (~valid_q),
        .valid (free_any),
        .index (free_index),
        .multi (free_multi)
    );

    always_comb begin
        srch_d       = '0;
        srch_d.valid = search_i && enc_valid;
        srch_d.index = search_i ? MAX_IDX_W'(enc_index) : '0;
        srch_d.multi = search_i && enc_multi;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            valid_q <= nxt_valid;
            count_q <= count_q + CW'(inc) - CW'(dec);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= nxt_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            read_valid_o <= 1'b0;
            read_value_o <= '0;
            srch_q       <= '0;
        end else begin
            srch_q <= srch_d;
            if (read_i) begin
                read_valid_o <= view_valid[read_index_i];
                read_value_o <= view_valid[read_index_i] ? view_data[read_index_i] : '0;
            end else begin
                read_valid_o <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{srch_q.index[MAX_IDX_W-1:DEPTH_LOG2], free_any, free_multi};

    assign search_valid_o = srch_q.valid;
    assign search_index_o = srch_q.index[DEPTH_LOG2-1:0];
    assign search_multi_o = srch_q.multi;
    assign count_o        = count_q;
    assign full_o         = (count_q == CW'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign free_index_o   = free_index;

endmodule

// File: tb/tb_cam_multi.sv
// Directed table-driven bench for cam_multi; expectations follow CAM_MULTI_BYPASS_EN when defined.
module tb_cam_multi;

    localparam int DW    = 32;
    localparam int L2    = 5;
    localparam int DEPTH = 1 << L2;

`ifdef CAM_MULTI_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic          read_i, write_i, inval_i, search_i;
    logic [L2-1:0] read_index_i, write_index_i, inval_index_i;
    logic [DW-1:0] write_data_i, search_data_i;
    logic          read_valid_o, search_valid_o, search_multi_o, full_o, empty_o;
    logic [DW-1:0] read_value_o;
    logic [L2-1:0] search_index_o, free_index_o;
    logic [L2:0]   count_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic          rd;
        logic [L2-1:0] ridx;
        logic          wr;
        logic [L2-1:0] widx;
        logic [DW-1:0] wdata;
        logic          inv;
        logic [L2-1:0] iidx;
        logic          sr;
        logic [DW-1:0] sdata;
        logic          e_rv;
        logic          chk_rval;
        logic [DW-1:0] e_rval;
        logic          e_sv;
        logic [L2-1:0] e_si;
        logic          e_sm;
        logic [L2:0]   e_cnt;
        logic [L2-1:0] e_free;
    } vec_t;

    vec_t vecs[$];

    cam_multi #(.DATA_WIDTH(DW), .DEPTH_LOG2(L2)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .read_i         (read_i),
        .read_index_i   (read_index_i),
        .write_i        (write_i),
        .write_index_i  (write_index_i),
        .write_data_i   (write_data_i),
        .inval_i        (inval_i),
        .inval_index_i  (inval_index_i),
        .search_i       (search_i),
        .search_data_i  (search_data_i),
        .read_valid_o   (read_valid_o),
        .read_value_o   (read_value_o),
        .search_valid_o (search_valid_o),
        .search_index_o (search_index_o),
        .search_multi_o (search_multi_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .free_index_o   (free_index_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(
        input logic rd, input int ridx, input logic wr, input int widx, input logic [DW-1:0] wdata,
        input logic inv, input int iidx, input logic sr, input logic [DW-1:0] sdata,
        input logic e_rv, input logic chk_rval, input logic [DW-1:0] e_rval,
        input logic e_sv, input int e_si, input logic e_sm, input int e_cnt, input int e_free);
        vec_t v;
        v.rd = rd;     v.ridx = L2'(ridx);
        v.wr = wr;     v.widx = L2'(widx);   v.wdata = wdata;
        v.inv = inv;   v.iidx = L2'(iidx);
        v.sr = sr;     v.sdata = sdata;
        v.e_rv = e_rv; v.chk_rval = chk_rval; v.e_rval = e_rval;
        v.e_sv = e_sv; v.e_si = L2'(e_si);   v.e_sm = e_sm;
        v.e_cnt = (L2+1)'(e_cnt);            v.e_free = L2'(e_free);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic idle_inputs();
        read_i = 1'b0;  read_index_i = '0;
        write_i = 1'b0; write_index_i = '0; write_data_i = '0;
        inval_i = 1'b0; inval_index_i = '0;
        search_i = 1'b0; search_data_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        read_i = v.rd;   read_index_i = v.ridx;
        write_i = v.wr;  write_index_i = v.widx; write_data_i = v.wdata;
        inval_i = v.inv; inval_index_i = v.iidx;
        search_i = v.sr; search_data_i = v.sdata;
        @(posedge clk);
        #1;
        check({tag, ".read_valid"}, 64'(read_valid_o), 64'(v.e_rv));
        if (v.chk_rval) check({tag, ".read_value"}, 64'(read_value_o), 64'(v.e_rval));
        check({tag, ".search_valid"}, 64'(search_valid_o), 64'(v.e_sv));
        check({tag, ".search_index"}, 64'(search_index_o), 64'(v.e_si));
        check({tag, ".search_multi"}, 64'(search_multi_o), 64'(v.e_sm));
        check({tag, ".count"}, 64'(count_o), 64'(v.e_cnt));
        check({tag, ".full"}, 64'(full_o), 64'(v.e_cnt == (L2+1)'(DEPTH)));
        check({tag, ".empty"}, 64'(empty_o), 64'(v.e_cnt == '0));
        check({tag, ".free_index"}, 64'(free_index_o), 64'(v.e_free));
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        #12;
        check("rst.read_valid", 64'(read_valid_o), 64'd0);
        check("rst.count", 64'(count_o), 64'd0);
        check("rst.empty", 64'(empty_o), 64'd1);
        check("rst.free_index", 64'(free_index_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;

        //           rd ri wr wi wdata         iv ii sr sdata         rv crv rval                       sv si sm cnt free
        vecs.push_back(mkv(1, 3, 0, 0, 0,            0, 0, 0, 0,            0, 1, 0,                        0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,            0, 1, 0,                        0, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            0, 0, 1, 32'hDEADBEEF, 0, 1, 0,                        1, 5, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 1, 2, 32'hA5,       0, 0, 0, 0,            0, 1, 0,                        0, 0, 0, 2, 0));
        vecs.push_back(mkv(0, 0, 1, 9, 32'hA5,       0, 0, 0, 0,            0, 1, 0,                        0, 0, 0, 3, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            0, 0, 1, 32'hA5,       0, 1, 0,                        1, 2, 1, 3, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            1, 2, 0, 0,            0, 1, 0,                        0, 0, 0, 2, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            0, 0, 1, 32'hA5,       0, 1, 0,                        1, 9, 0, 2, 0));
        vecs.push_back(mkv(1, 7, 1, 7, 32'h11,       1, 7, 0, 0,            BP, 1, BP ? 32'h11 : 32'h0,     0, 0, 0, 3, 0));
        vecs.push_back(mkv(1, 7, 0, 0, 0,            0, 0, 0, 0,            1, 1, 32'h11,                   0, 0, 0, 3, 0));
        vecs.push_back(mkv(1, 2, 0, 0, 0,            0, 0, 0, 0,            0, 1, 0,                        0, 0, 0, 3, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            1, 12, 0, 0,           0, 1, 0,                        0, 0, 0, 3, 0));
        vecs.push_back(mkv(1, 9, 1, 9, 32'h22,       0, 0, 0, 0,            1, 1, BP ? 32'h22 : 32'hA5,     0, 0, 0, 3, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            1, 9, 1, 32'h22,       0, 0, 0,                        !BP, BP ? 0 : 9, 0, 2, 0));
        vecs.push_back(mkv(1, 5, 0, 0, 0,            0, 0, 0, 0,            1, 1, 32'hDEADBEEF,             0, 0, 0, 2, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 1, 32'hDEADBEEF,             0, 0, 0, 2, 0));
        vecs.push_back(mkv(0, 0, 1, 0, 32'h33,       1, 5, 0, 0,            0, 1, 32'hDEADBEEF,             0, 0, 0, 2, 1));
        vecs.push_back(mkv(0, 0, 0, 0, 0,            0, 0, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF,             0, 0, 0, 2, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 0,            0, 0, 1, 32'h11,       1, 1, 32'h33,                   1, 7, 0, 2, 1));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Fill every entry, then overwrite and punch a hole.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            write_i = 1'b1; write_index_i = L2'(i); write_data_i = 32'h100 + 32'(i);
        end
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 1, 32'h105, 0, 0, 0, 1, 5, 0, DEPTH, 0), "fill");
        apply(mkv(0, 0, 1, 0, 32'h105, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEPTH, 0), "overwrite");
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 1, 32'h105, 0, 0, 0, 1, 0, 1, DEPTH, 0), "dup_search");
        apply(mkv(0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, DEPTH - 1, 4), "hole");
        apply(mkv(0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, DEPTH - 1, 4), "reinval");

        // Asynchronous reset while a search and read result are being held.
        do_reset();
        apply(mkv(0, 0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "mr_w1");
        apply(mkv(0, 0, 1, 2, 32'h41, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0), "mr_w2");
        apply(mkv(0, 0, 1, 3, 32'h42, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0), "mr_w3");
        apply(mkv(1, 3, 0, 0, 0, 0, 0, 1, 32'h41, 1, 1, 32'h42, 1, 2, 0, 3, 0), "mr_hit");
        #1;
        reset_i = 1'b1;
        #1;
        check("mr.search_valid", 64'(search_valid_o), 64'd0);
        check("mr.search_index", 64'(search_index_o), 64'd0);
        check("mr.read_valid", 64'(read_valid_o), 64'd0);
        check("mr.read_value", 64'(read_value_o), 64'd0);
        check("mr.count", 64'(count_o), 64'd0);
        check("mr.empty", 64'(empty_o), 64'd1);
        @(negedge clk);
        reset_i = 1'b0;
        apply(mkv(1, 2, 0, 0, 0, 0, 0, 1, 32'h41, 0, 1, 0, 0, 0, 0, 0, 0), "mr_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
